// File: rtl/fetch_thread_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_thread_sequencer_pkg
// Shared definitions for the multithreaded fetch sequencer:
//   - thread_state_e : per-thread scheduling state
//   - pc_src_e       : PC update sources, encoded in priority order
//   - bundle_bytes() : byte size of one fetch bundle
//   - pc_select()    : resolves competing PC updates for one thread
// No ports (package).
// ---------------------------------------------------------------------------
package fetch_thread_sequencer_pkg;

  // Scheduling state of one hardware thread.
  typedef enum logic [1:0] {
    THREAD_IDLE      = 2'd0,
    THREAD_READY     = 2'd1,
    THREAD_WAIT_MISS = 2'd2
  } thread_state_e;

  // Sources that can update a thread PC in one cycle. A lower encoding wins
  // when several fire together; PC_HOLD means no update.
  typedef enum logic [2:0] {
    PC_REDIRECT = 3'd0,
    PC_MISS     = 3'd1,
    PC_ADJUST   = 3'd2,
    PC_ISSUE    = 3'd3,
    PC_HOLD     = 3'd4
  } pc_src_e;

  // Every instruction is one 32-bit word.
  localparam int INST_BYTES = 4;

  function automatic int bundle_bytes(input int insts);
    return INST_BYTES * insts;
  endfunction

  // Priority: redirect > miss > adjust > issue increment.
  function automatic pc_src_e pc_select(input logic redirect, input logic miss,
                                        input logic adjust, input logic issue);
    if (redirect)    return PC_REDIRECT;
    else if (miss)   return PC_MISS;
    else if (adjust) return PC_ADJUST;
    else if (issue)  return PC_ISSUE;
    else             return PC_HOLD;
  endfunction

endpackage

// File: rtl/fetch_thread_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_thread_sequencer_if
// Bundles all command, redirect, miss, adjust, ID and fetch-output signals of
// the fetch sequencer. The slave modport belongs to the sequencer; the master
// modport belongs to whatever drives it (front-end control or a testbench).
//   command : fetchStall_i, threadEnable_i
//   redirect: redirectEn_i, redirectThread_i, redirectAddress_i
//   miss    : missEn_i, missThread_i, missAddress_i
//   resolve : missResolveEn_i, missResolveThread_i
//   adjust  : adjustEn_i, adjustThread_i, adjustAddress_i, adjustCount_i
//   ids     : pidWriteEn_i, tidWriteEn_i, idThread_i, pid_i, tid_i
//   fetch   : fetchEnable_o, fetchAddress_o, fetchThread_o, fetchPid_o, fetchTid_o
// ---------------------------------------------------------------------------
interface fetch_thread_sequencer_if
  import fetch_thread_sequencer_pkg::*;
#(
  parameter int addressWidth = 64,
  parameter int threadCount  = 4,
  parameter int PidSize      = 32,
  parameter int TidSize      = 64
);
  localparam int tw = $clog2(threadCount);

  logic                    fetchStall_i;
  logic [threadCount-1:0]  threadEnable_i;

  logic                    redirectEn_i;
  logic [tw-1:0]           redirectThread_i;
  logic [addressWidth-1:0] redirectAddress_i;

  logic                    missEn_i;
  logic [tw-1:0]           missThread_i;
  logic [addressWidth-1:0] missAddress_i;

  logic                    missResolveEn_i;
  logic [tw-1:0]           missResolveThread_i;

  logic                    adjustEn_i;
  logic [tw-1:0]           adjustThread_i;
  logic [addressWidth-1:0] adjustAddress_i;
  logic [2:0]              adjustCount_i;

  logic                    pidWriteEn_i;
  logic                    tidWriteEn_i;
  logic [tw-1:0]           idThread_i;
  logic [PidSize-1:0]      pid_i;
  logic [TidSize-1:0]      tid_i;

  logic                    fetchEnable_o;
  logic [addressWidth-1:0] fetchAddress_o;
  logic [tw-1:0]           fetchThread_o;
  logic [PidSize-1:0]      fetchPid_o;
  logic [TidSize-1:0]      fetchTid_o;

  modport master (
    output fetchStall_i, threadEnable_i,
    output redirectEn_i, redirectThread_i, redirectAddress_i,
    output missEn_i, missThread_i, missAddress_i,
    output missResolveEn_i, missResolveThread_i,
    output adjustEn_i, adjustThread_i, adjustAddress_i, adjustCount_i,
    output pidWriteEn_i, tidWriteEn_i, idThread_i, pid_i, tid_i,
    input  fetchEnable_o, fetchAddress_o, fetchThread_o, fetchPid_o, fetchTid_o
  );

  modport slave (
    input  fetchStall_i, threadEnable_i,
    input  redirectEn_i, redirectThread_i, redirectAddress_i,
    input  missEn_i, missThread_i, missAddress_i,
    input  missResolveEn_i, missResolveThread_i,
    input  adjustEn_i, adjustThread_i, adjustAddress_i, adjustCount_i,
    input  pidWriteEn_i, tidWriteEn_i, idThread_i, pid_i, tid_i,
    output fetchEnable_o, fetchAddress_o, fetchThread_o, fetchPid_o, fetchTid_o
  );

endinterface

// File: rtl/fetch_thread_sequencer_arbiter.sv
// ---------------------------------------------------------------------------
// rr_thread_arbiter
// Purely combinational round-robin picker. Searches the eligible mask
// starting at the thread after last_thread, wrapping around, and returns the
// first hit.
//   eligible    : per-thread request mask
//   last_thread : most recently issued thread
//   grant       : selected thread (valid only when valid=1)
//   valid       : at least one thread is eligible
// ---------------------------------------------------------------------------
module rr_thread_arbiter
  import fetch_thread_sequencer_pkg::*;
#(
  parameter int threadCount = 4,
  parameter int tw          = $clog2(threadCount)
) (
  input  logic [threadCount-1:0] eligible,
  input  logic [tw-1:0]          last_thread,
  output logic [tw-1:0]          grant,
  output logic                   valid
);

  // threadCount is a power of two, so the tw-bit add wraps cyclically; the
  // final step (i == threadCount) revisits last_thread itself.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = 1; i <= threadCount; i++) begin
      if (!valid && eligible[last_thread + tw'(i)]) begin
        grant = last_thread + tw'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_thread_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_thread_sequencer
// Multithreaded instruction-fetch sequencer. Keeps a PC, PID, TID and
// scheduling state per hardware thread, picks one ready thread per cycle in
// round-robin order, and registers its fetch request one cycle later.
//   clock_i : rising-edge clock
//   reset_i : synchronous active-high reset
//   bus     : slave side of fetch_thread_sequencer_if (commands, redirect,
//             miss/resolve, partial-bundle adjust, ID writes, fetch outputs)
// ---------------------------------------------------------------------------
module fetch_thread_sequencer
  import fetch_thread_sequencer_pkg::*;
#(
  parameter int                      addressWidth = 64,
  parameter int                      threadCount  = 4,
  parameter int                      bundleInsts  = 4,
  parameter int                      PidSize      = 32,
  parameter int                      TidSize      = 64,
  parameter logic [addressWidth-1:0] resetVector  = '0
) (
  input logic                     clock_i,
  input logic                     reset_i,
  fetch_thread_sequencer_if.slave bus
);

  localparam int tw          = $clog2(threadCount);
  localparam int bundleBytes = bundle_bytes(bundleInsts);

  thread_state_e           state_q [threadCount];
  thread_state_e           state_d [threadCount];
  logic [addressWidth-1:0] pc_q    [threadCount];
  logic [addressWidth-1:0] pc_d    [threadCount];
  logic [PidSize-1:0]      pid_q   [threadCount];
  logic [TidSize-1:0]      tid_q   [threadCount];
  logic [tw-1:0]           last_thread_q;

  logic [threadCount-1:0]  redirect_hit;
  logic [threadCount-1:0]  miss_hit;
  logic [threadCount-1:0]  resolve_hit;
  logic [threadCount-1:0]  adjust_hit;
  logic [threadCount-1:0]  eligible;
  logic [tw-1:0]           grant;
  logic                    grant_valid;
  logic                    issue;
  logic [addressWidth-1:0] redirect_pc;
  logic [addressWidth-1:0] adjust_pc;

  logic                    fetch_enable_q;
  logic [addressWidth-1:0] fetch_address_q;
  logic [tw-1:0]           fetch_thread_q;
  logic [PidSize-1:0]      fetch_pid_q;
  logic [TidSize-1:0]      fetch_tid_q;

  // A thread touched by redirect, miss or adjust this cycle has a PC that is
  // about to change, so it sits out arbitration until the new PC is in place.
  always_comb begin
    redirect_hit = '0;
    miss_hit     = '0;
    resolve_hit  = '0;
    adjust_hit   = '0;
    eligible     = '0;
    for (int t = 0; t < threadCount; t++) begin
      redirect_hit[t] = bus.redirectEn_i    && (bus.redirectThread_i    == tw'(t));
      miss_hit[t]     = bus.missEn_i        && (bus.missThread_i        == tw'(t));
      resolve_hit[t]  = bus.missResolveEn_i && (bus.missResolveThread_i == tw'(t));
      adjust_hit[t]   = bus.adjustEn_i      && (bus.adjustThread_i      == tw'(t));
      eligible[t]     = (state_q[t] == THREAD_READY) &&
                        !redirect_hit[t] && !miss_hit[t] && !adjust_hit[t];
    end
  end

  rr_thread_arbiter #(
    .threadCount (threadCount),
    .tw          (tw)
  ) u_arbiter (
    .eligible    (eligible),
    .last_thread (last_thread_q),
    .grant       (grant),
    .valid       (grant_valid)
  );

  assign issue = !bus.fetchStall_i && grant_valid;

  // Redirect targets are word aligned; the two lowest address bits are
  // dropped. Adjust resumes after the instructions already consumed.
  assign redirect_pc = {bus.redirectAddress_i[addressWidth-1:2], 2'b00};
  assign adjust_pc   = bus.adjustAddress_i + addressWidth'({bus.adjustCount_i, 2'b00});

  // Next PC per thread; all arithmetic wraps modulo 2^addressWidth.
  always_comb begin
    for (int t = 0; t < threadCount; t++) begin
      pc_d[t] = pc_q[t];
      case (pc_select(redirect_hit[t], miss_hit[t], adjust_hit[t],
                      issue && (grant == tw'(t))))
        PC_REDIRECT: pc_d[t] = redirect_pc;
        PC_MISS:     pc_d[t] = bus.missAddress_i;
        PC_ADJUST:   pc_d[t] = adjust_pc;
        PC_ISSUE:    pc_d[t] = pc_q[t] + addressWidth'(bundleBytes);
        default:     pc_d[t] = pc_q[t];
      endcase
    end
  end

  // Next scheduling state per thread. Disabling a thread wins over all else.
  // A miss beats a same-cycle resolve, and a redirect flushes a pending miss.
  always_comb begin
    for (int t = 0; t < threadCount; t++) begin
      state_d[t] = state_q[t];
      if (!bus.threadEnable_i[t]) begin
        state_d[t] = THREAD_IDLE;
      end else begin
        case (state_q[t])
          THREAD_IDLE: begin
            state_d[t] = THREAD_READY;
          end
          THREAD_READY: begin
            if (miss_hit[t] && !redirect_hit[t]) state_d[t] = THREAD_WAIT_MISS;
          end
          THREAD_WAIT_MISS: begin
            if (redirect_hit[t])     state_d[t] = THREAD_READY;
            else if (miss_hit[t])    state_d[t] = THREAD_WAIT_MISS;
            else if (resolve_hit[t]) state_d[t] = THREAD_READY;
          end
          default: begin
            state_d[t] = THREAD_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock_i) begin
    for (int t = 0; t < threadCount; t++) begin
      if (reset_i) state_q[t] <= THREAD_IDLE;
      else         state_q[t] <= state_d[t];
    end
  end

  // Per-thread PC and ID registers. ID writes land at the edge, so an issue
  // in the same cycle still sees the previous value.
  always_ff @(posedge clock_i) begin
    for (int t = 0; t < threadCount; t++) begin
      if (reset_i) begin
        pc_q[t]  <= resetVector;
        pid_q[t] <= '0;
        tid_q[t] <= '0;
      end else begin
        pc_q[t] <= pc_d[t];
        if (bus.pidWriteEn_i && (bus.idThread_i == tw'(t))) pid_q[t] <= bus.pid_i;
        if (bus.tidWriteEn_i && (bus.idThread_i == tw'(t))) tid_q[t] <= bus.tid_i;
      end
    end
  end

  // Fetch output registers. A stall freezes everything; with no stall the
  // enable follows the grant while address/thread/IDs only load on an issue.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      last_thread_q   <= tw'(threadCount - 1);
      fetch_enable_q  <= 1'b0;
      fetch_address_q <= '0;
      fetch_thread_q  <= '0;
      fetch_pid_q     <= '0;
      fetch_tid_q     <= '0;
    end else if (!bus.fetchStall_i) begin
      fetch_enable_q <= issue;
      if (issue) begin
        last_thread_q   <= grant;
        fetch_address_q <= pc_q[grant];
        fetch_thread_q  <= grant;
        fetch_pid_q     <= pid_q[grant];
        fetch_tid_q     <= tid_q[grant];
      end
    end
  end

  assign bus.fetchEnable_o  = fetch_enable_q;
  assign bus.fetchAddress_o = fetch_address_q;
  assign bus.fetchThread_o  = fetch_thread_q;
  assign bus.fetchPid_o     = fetch_pid_q;
  assign bus.fetchTid_o     = fetch_tid_q;

endmodule

// File: tb/tb_fetch_thread_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_thread_sequencer
// Self-checking bench for fetch_thread_sequencer: directed scenarios for
// start-up order, miss/resolve, redirect flush, partial-bundle adjust, stall
// and address wrap, followed by randomized traffic. A behavioural model
// holds per-thread PCs, IDs and states and predicts every registered output.
// ---------------------------------------------------------------------------
module tb_fetch_thread_sequencer;

  localparam int AW = 64;
  localparam int TC = 4;
  localparam int PW = 32;
  localparam int TW = 64;

  localparam int M_IDLE  = 0;
  localparam int M_READY = 1;
  localparam int M_WAIT  = 2;

  logic clk = 1'b0;
  logic rst;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_thread_sequencer_if #(
    .addressWidth (AW),
    .threadCount  (TC),
    .PidSize      (PW),
    .TidSize      (TW)
  ) bus ();

  fetch_thread_sequencer #(
    .addressWidth (AW),
    .threadCount  (TC),
    .bundleInsts  (4),
    .PidSize      (PW),
    .TidSize      (TW),
    .resetVector  ('0)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [63:0] m_pc  [TC];
  logic [31:0] m_pid [TC];
  logic [63:0] m_tid [TC];
  int          m_st  [TC];
  int          m_last;
  logic        exp_en;
  logic [63:0] exp_addr;
  int          exp_thr;
  logic [31:0] exp_pid;
  logic [63:0] exp_tid;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit targeted(input int t);
    return (bus.redirectEn_i && int'(bus.redirectThread_i) == t) ||
           (bus.missEn_i     && int'(bus.missThread_i)     == t) ||
           (bus.adjustEn_i   && int'(bus.adjustThread_i)   == t);
  endfunction

  // Advances the model by one clock using the inputs currently driven.
  task automatic updateModel();
    int pick;
    int cand;
    bit rd, ms, ad, rs;
    if (rst) begin
      for (int t = 0; t < TC; t++) begin
        m_pc[t] = 64'h0; m_pid[t] = 32'h0; m_tid[t] = 64'h0; m_st[t] = M_IDLE;
      end
      m_last = TC - 1;
      exp_en = 1'b0; exp_addr = 64'h0; exp_thr = 0; exp_pid = 32'h0; exp_tid = 64'h0;
      return;
    end
    pick = -1;
    if (!bus.fetchStall_i) begin
      for (int k = 1; k <= TC; k++) begin
        cand = (m_last + k) % TC;
        if (pick < 0 && m_st[cand] == M_READY && !targeted(cand)) pick = cand;
      end
      exp_en = (pick >= 0);
      if (pick >= 0) begin
        exp_addr = m_pc[pick];
        exp_thr  = pick;
        exp_pid  = m_pid[pick];
        exp_tid  = m_tid[pick];
        m_last   = pick;
      end
    end
    for (int t = 0; t < TC; t++) begin
      rd = bus.redirectEn_i    && int'(bus.redirectThread_i)    == t;
      ms = bus.missEn_i        && int'(bus.missThread_i)        == t;
      ad = bus.adjustEn_i      && int'(bus.adjustThread_i)      == t;
      rs = bus.missResolveEn_i && int'(bus.missResolveThread_i) == t;
      if (rd)             m_pc[t] = bus.redirectAddress_i & ~64'h3;
      else if (ms)        m_pc[t] = bus.missAddress_i;
      else if (ad)        m_pc[t] = bus.adjustAddress_i + 64'(bus.adjustCount_i) * 4;
      else if (t == pick) m_pc[t] = m_pc[t] + 64'd16;
      if (!bus.threadEnable_i[t])             m_st[t] = M_IDLE;
      else if (m_st[t] == M_IDLE)             m_st[t] = M_READY;
      else if (m_st[t] == M_READY && ms && !rd) m_st[t] = M_WAIT;
      else if (m_st[t] == M_WAIT && rd)       m_st[t] = M_READY;
      else if (m_st[t] == M_WAIT && !ms && rs) m_st[t] = M_READY;
    end
    if (bus.pidWriteEn_i) m_pid[bus.idThread_i] = bus.pid_i;
    if (bus.tidWriteEn_i) m_tid[bus.idThread_i] = bus.tid_i;
  endtask

  task automatic clearInputs();
    rst                     = 1'b0;
    bus.fetchStall_i        = 1'b0;
    bus.threadEnable_i      = 4'hF;
    bus.redirectEn_i        = 1'b0;
    bus.redirectThread_i    = 2'd0;
    bus.redirectAddress_i   = 64'h0;
    bus.missEn_i            = 1'b0;
    bus.missThread_i        = 2'd0;
    bus.missAddress_i       = 64'h0;
    bus.missResolveEn_i     = 1'b0;
    bus.missResolveThread_i = 2'd0;
    bus.adjustEn_i          = 1'b0;
    bus.adjustThread_i      = 2'd0;
    bus.adjustAddress_i     = 64'h0;
    bus.adjustCount_i       = 3'd0;
    bus.pidWriteEn_i        = 1'b0;
    bus.tidWriteEn_i        = 1'b0;
    bus.idThread_i          = 2'd0;
    bus.pid_i               = 32'h0;
    bus.tid_i               = 64'h0;
  endtask

  // One clock: predict, clock the DUT, compare all outputs 1 time unit later.
  task automatic applyStimulus();
    updateModel();
    @(posedge clk);
    #1;
    checkOutput("enable",  64'(bus.fetchEnable_o), 64'(exp_en));
    checkOutput("address", bus.fetchAddress_o,     exp_addr);
    checkOutput("thread",  64'(bus.fetchThread_o), 64'(exp_thr));
    checkOutput("pid",     64'(bus.fetchPid_o),    64'(exp_pid));
    checkOutput("tid",     bus.fetchTid_o,         exp_tid);
  endtask

  // Idles until thread thr issues, then checks its address; bounded wait.
  task automatic waitIssue(input int thr, input logic [63:0] addr, input string tag);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      clearInputs();
      applyStimulus();
      if (bus.fetchEnable_o && int'(bus.fetchThread_o) == thr) begin
        found = 1'b1;
        checkOutput(tag, bus.fetchAddress_o, addr);
      end
    end
    if (!found) checkOutput({tag, "_timeout"}, 64'(found), 64'd1);
  endtask

  initial begin
    int t1_issues;
    logic        held_en;
    logic [63:0] held_addr;

    // Reset with unrelated traffic present; reset must win.
    clearInputs();
    rst = 1'b1;
    bus.missEn_i = 1'b1; bus.missThread_i = 2'd1; bus.missAddress_i = 64'h77;
    bus.pidWriteEn_i = 1'b1; bus.pid_i = 32'hDEAD;
    applyStimulus();
    checkOutput("reset_en",   64'(bus.fetchEnable_o), 64'd0);
    checkOutput("reset_addr", bus.fetchAddress_o,     64'd0);

    // Start-up order: one cycle to leave IDLE, then 0,1,2,3,0.
    clearInputs();
    applyStimulus();
    checkOutput("startup_idle", 64'(bus.fetchEnable_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      clearInputs();
      applyStimulus();
      checkOutput("startup_thread", 64'(bus.fetchThread_o), 64'(i % 4));
      checkOutput("startup_addr",   bus.fetchAddress_o,     (i == 4) ? 64'h10 : 64'h0);
    end

    // Thread 1 misses to 0x40 and must be skipped until resolved.
    clearInputs();
    bus.missEn_i = 1'b1; bus.missThread_i = 2'd1; bus.missAddress_i = 64'h40;
    applyStimulus();
    t1_issues = 0;
    for (int i = 0; i < 6; i++) begin
      clearInputs();
      applyStimulus();
      if (bus.fetchEnable_o && bus.fetchThread_o == 2'd1) t1_issues++;
    end
    checkOutput("miss_skip", 64'(t1_issues), 64'd0);
    clearInputs();
    bus.missResolveEn_i = 1'b1; bus.missResolveThread_i = 2'd1;
    applyStimulus();
    waitIssue(1, 64'h40, "miss_resume");

    // Redirect during a pending miss flushes it; low bits are cleared.
    clearInputs();
    bus.missEn_i = 1'b1; bus.missThread_i = 2'd2; bus.missAddress_i = 64'h80;
    applyStimulus();
    clearInputs();
    bus.redirectEn_i = 1'b1; bus.redirectThread_i = 2'd2; bus.redirectAddress_i = 64'h1003;
    applyStimulus();
    waitIssue(2, 64'h1000, "redirect_flush");

    // Partial bundle: two instructions consumed from 0x20.
    clearInputs();
    bus.adjustEn_i = 1'b1; bus.adjustThread_i = 2'd0;
    bus.adjustAddress_i = 64'h20; bus.adjustCount_i = 3'd2;
    applyStimulus();
    waitIssue(0, 64'h28, "adjust");

    // Three stalled cycles with a redirect of thread 3 in the first one.
    held_en   = exp_en;
    held_addr = exp_addr;
    for (int i = 0; i < 3; i++) begin
      clearInputs();
      bus.fetchStall_i = 1'b1;
      if (i == 0) begin
        bus.redirectEn_i = 1'b1; bus.redirectThread_i = 2'd3; bus.redirectAddress_i = 64'h2000;
      end
      applyStimulus();
      checkOutput("stall_en",   64'(bus.fetchEnable_o), 64'(held_en));
      checkOutput("stall_addr", bus.fetchAddress_o,     held_addr);
    end
    waitIssue(3, 64'h2000, "stall_redirect");

    // PC wraps to zero after the top bundle.
    clearInputs();
    bus.redirectEn_i = 1'b1; bus.redirectThread_i = 2'd0;
    bus.redirectAddress_i = 64'hFFFF_FFFF_FFFF_FFF0;
    applyStimulus();
    waitIssue(0, 64'hFFFF_FFFF_FFFF_FFF0, "wrap_top");
    waitIssue(0, 64'h0, "wrap_zero");

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      clearInputs();
      rst                     = ($urandom_range(0, 99) == 0);
      bus.fetchStall_i        = ($urandom_range(0, 3) == 0);
      bus.threadEnable_i      = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      bus.redirectEn_i        = ($urandom_range(0, 7) == 0);
      bus.redirectThread_i    = 2'($urandom);
      bus.redirectAddress_i   = {$urandom, $urandom};
      bus.missEn_i            = ($urandom_range(0, 5) == 0);
      bus.missThread_i        = 2'($urandom);
      bus.missAddress_i       = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0
                                                            : {$urandom, $urandom};
      bus.missResolveEn_i     = ($urandom_range(0, 3) == 0);
      bus.missResolveThread_i = 2'($urandom);
      bus.adjustEn_i          = ($urandom_range(0, 7) == 0);
      bus.adjustThread_i      = 2'($urandom);
      bus.adjustAddress_i     = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                                            : {$urandom, $urandom};
      bus.adjustCount_i       = 3'($urandom_range(1, 3));
      bus.pidWriteEn_i        = ($urandom_range(0, 4) == 0);
      bus.tidWriteEn_i        = ($urandom_range(0, 4) == 0);
      bus.idThread_i          = 2'($urandom);
      bus.pid_i               = $urandom;
      bus.tid_i               = {$urandom, $urandom};
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
